// File: rtl/reloj_ms_multicanal_if.sv
// Period-write bus for the multi-channel millisecond clock divider.
// The master drives a single-cycle write of a new period into one channel.
interface reloj_ms_multicanal_if #(
  parameter int ANCHO_CANAL = 2,
  parameter int ANCHO_MS    = 16
);
  logic                   wr_en;
  logic [ANCHO_CANAL-1:0] wr_canal;
  logic [ANCHO_MS-1:0]    wr_dato;

  modport master (output wr_en, wr_canal, wr_dato);
  modport slave  (input  wr_en, wr_canal, wr_dato);
endinterface

// File: rtl/reloj_ms_multicanal.sv
// Shared 1 ms prescaler feeding NUM_CANALES independently programmable dividers.
// Each channel emits a one-cycle pulse and a 50% square wave per period.
module reloj_ms_canal #(
  parameter int ANCHO_MS        = 16,
  parameter int PERIODO_INICIAL = 1
) (
  input  logic                clock_FPGA,
  input  logic                reset,
  input  logic                tick_i,
  input  logic                we_i,
  input  logic [ANCHO_MS-1:0] dato_i,
  input  logic                hab_i,
  output logic                pulso_o,
  output logic                reloj_o
);
  localparam logic [ANCHO_MS-1:0] UNO = ANCHO_MS'(1);

  logic [ANCHO_MS-1:0] periodo_q, periodo_d;
  logic [ANCHO_MS-1:0] contador_q, contador_d;
  logic                pulso_q, pulso_d;
  logic                reloj_q, reloj_d;

  // Write beats disable, disable beats stall, stall beats counting.
  always_comb begin
    periodo_d  = periodo_q;
    contador_d = contador_q;
    pulso_d    = 1'b0;
    reloj_d    = reloj_q;
    if (we_i) begin
      periodo_d  = dato_i;
      contador_d = '0;
    end else if (!hab_i) begin
      contador_d = '0;
      reloj_d    = 1'b0;
    end else if (periodo_q == '0) begin
      contador_d = '0;
    end else if (tick_i) begin
      if (contador_q == periodo_q - UNO) begin
        contador_d = '0;
        pulso_d    = 1'b1;
        reloj_d    = ~reloj_q;
      end else begin
        contador_d = contador_q + UNO;
      end
    end
  end

  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      periodo_q  <= ANCHO_MS'(PERIODO_INICIAL);
      contador_q <= '0;
      pulso_q    <= 1'b0;
      reloj_q    <= 1'b0;
    end else begin
      periodo_q  <= periodo_d;
      contador_q <= contador_d;
      pulso_q    <= pulso_d;
      reloj_q    <= reloj_d;
    end
  end

  assign pulso_o = pulso_q;
  assign reloj_o = reloj_q;
endmodule

module reloj_ms_multicanal #(
  parameter  int CICLOS_POR_MS   = 50000,
  parameter  int ANCHO_CANAL     = 2,
  parameter  int ANCHO_MS        = 16,
  parameter  int PERIODO_INICIAL = 1,
  localparam int NUM_CANALES     = 2**ANCHO_CANAL
) (
  input  logic                   clock_FPGA,
  input  logic                   reset,
  input  logic [NUM_CANALES-1:0] habilitar,
  reloj_ms_multicanal_if.slave   wr,
  output logic                   tick_ms,
  output logic [NUM_CANALES-1:0] pulso_N_ms,
  output logic [NUM_CANALES-1:0] reloj_N_ms
);
  localparam int               W_PRE   = $clog2(CICLOS_POR_MS);
  localparam logic [W_PRE-1:0] PRE_MAX = W_PRE'(CICLOS_POR_MS - 1);

  logic [W_PRE-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;

  always_comb begin
    presc_d = presc_q + W_PRE'(1);
    tick_d  = 1'b0;
    if (presc_q == PRE_MAX) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_ms = tick_q;

  logic [NUM_CANALES-1:0] we;

  for (genvar g = 0; g < NUM_CANALES; g++) begin : g_canal
    assign we[g] = wr.wr_en && (wr.wr_canal == ANCHO_CANAL'(g));

    reloj_ms_canal #(
      .ANCHO_MS       (ANCHO_MS),
      .PERIODO_INICIAL(PERIODO_INICIAL)
    ) u_canal (
      .clock_FPGA(clock_FPGA),
      .reset     (reset),
      .tick_i    (tick_q),
      .we_i      (we[g]),
      .dato_i    (wr.wr_dato),
      .hab_i     (habilitar[g]),
      .pulso_o   (pulso_N_ms[g]),
      .reloj_o   (reloj_N_ms[g])
    );
  end
endmodule

// File: tb/tb_reloj_ms_multicanal.sv
// Directed bench for reloj_ms_multicanal with CICLOS_POR_MS=4, two channels, 4-bit periods.
// Cycle n is the interval after the n-th rising edge with reset low; sampled 1 time unit after it.
module tb_reloj_ms_multicanal;
  localparam int CPM = 4, AC = 1, AM = 4, PI = 3, NC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] hab = '0;
  logic          tick;
  logic [NC-1:0] pulso, reloj;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  reloj_ms_multicanal_if #(.ANCHO_CANAL(AC), .ANCHO_MS(AM)) bus ();

  always #5 clk = ~clk;

  reloj_ms_multicanal #(
    .CICLOS_POR_MS  (CPM),
    .ANCHO_CANAL    (AC),
    .ANCHO_MS       (AM),
    .PERIODO_INICIAL(PI)
  ) dut (
    .clock_FPGA(clk),
    .reset     (rst),
    .habilitar (hab),
    .wr        (bus.slave),
    .tick_ms   (tick),
    .pulso_N_ms(pulso),
    .reloj_N_ms(reloj)
  );

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write(input logic [AC-1:0] ch, input logic [AM-1:0] d);
    bus.wr_en = 1'b1; bus.wr_canal = ch; bus.wr_dato = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  // Channel 1 runs at period 1 from the write at cycle 27 until the late reset:
  // pulse after each tick (cycles 29,33,...), square wave high on 29..32, 37..40, ...
  function automatic logic [1:0] exp_ch1(input int c);
    logic p, r;
    p = (c >= 29) && (c % 4 == 1);
    r = (c >= 29) && (((c - 29) / 4) % 2 == 0);
    return {r, p};
  endfunction

  task automatic test_reset;
    rst = 1'b1; hab = 2'b11;
    bus.wr_en = 1'b0; bus.wr_canal = '0; bus.wr_dato = '0;
    step(); step();
    n_chk++; if (tick !== 1'b0)   begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_chk++; if (pulso !== 2'b00) begin n_fail++; $display("FAIL reset_pulso got=%b exp=00", pulso); end
    n_chk++; if (reloj !== 2'b00) begin n_fail++; $display("FAIL reset_reloj got=%b exp=00", reloj); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_startup(input string tag);
    logic       et;
    logic [1:0] ep, er;
    for (int k = 0; k < 26; k++) begin
      step();
      et = (cyc % 4 == 0);
      ep = (cyc == 13 || cyc == 25) ? 2'b11 : 2'b00;
      er = (cyc >= 13 && cyc < 25) ? 2'b11 : 2'b00;
      n_chk++; if (tick !== et)  begin n_fail++; $display("FAIL %s_tick cyc=%0d got=%b exp=%b", tag, cyc, tick, et); end
      n_chk++; if (pulso !== ep) begin n_fail++; $display("FAIL %s_pulso cyc=%0d got=%b exp=%b", tag, cyc, pulso, ep); end
      n_chk++; if (reloj !== er) begin n_fail++; $display("FAIL %s_reloj cyc=%0d got=%b exp=%b", tag, cyc, reloj, er); end
    end
  endtask

  task automatic test_write_period;
    logic [1:0] e1;
    write(1'b1, 4'd1);
    while (1) begin
      e1 = exp_ch1(cyc);
      n_chk++; if ({reloj[1], pulso[1]} !== e1) begin n_fail++; $display("FAIL wr_ch1 cyc=%0d got=%b%b exp=%b", cyc, reloj[1], pulso[1], e1); end
      n_chk++; if ({reloj[0], pulso[0]} !== {cyc >= 37, cyc == 37}) begin n_fail++; $display("FAIL wr_ch0 cyc=%0d got=%b%b exp=%b%b", cyc, reloj[0], pulso[0], cyc >= 37, cyc == 37); end
      if (cyc >= 42) break;
      step();
    end
  endtask

  task automatic test_stall;
    logic [1:0] e1;
    write(1'b0, 4'd0);
    while (1) begin
      e1 = exp_ch1(cyc);
      n_chk++; if ({reloj[1], pulso[1]} !== e1) begin n_fail++; $display("FAIL stall_ch1 cyc=%0d got=%b%b exp=%b", cyc, reloj[1], pulso[1], e1); end
      n_chk++; if ({reloj[0], pulso[0]} !== 2'b10) begin n_fail++; $display("FAIL stall_ch0 cyc=%0d got=%b%b exp=10", cyc, reloj[0], pulso[0]); end
      if (cyc >= 52) break;
      step();
    end
    write(1'b0, 4'd3);
    while (1) begin
      n_chk++; if ({reloj[0], pulso[0]} !== {cyc < 65, cyc == 65}) begin n_fail++; $display("FAIL restart_ch0 cyc=%0d got=%b%b exp=%b%b", cyc, reloj[0], pulso[0], cyc < 65, cyc == 65); end
      if (cyc >= 65) break;
      step();
    end
  endtask

  task automatic test_disable;
    logic [1:0] e1;
    while (cyc < 80) begin
      step();
      n_chk++; if ({reloj[0], pulso[0]} !== {cyc >= 77, cyc == 77}) begin n_fail++; $display("FAIL pre_dis_ch0 cyc=%0d got=%b%b exp=%b%b", cyc, reloj[0], pulso[0], cyc >= 77, cyc == 77); end
    end
    hab = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if ({reloj[0], pulso[0]} !== 2'b00) begin n_fail++; $display("FAIL dis_ch0 cyc=%0d got=%b%b exp=00", cyc, reloj[0], pulso[0]); end
    end
    hab = 2'b11;
    while (cyc < 93) begin
      step();
      e1 = exp_ch1(cyc);
      n_chk++; if ({reloj[1], pulso[1]} !== e1) begin n_fail++; $display("FAIL dis_ch1 cyc=%0d got=%b%b exp=%b", cyc, reloj[1], pulso[1], e1); end
      n_chk++; if ({reloj[0], pulso[0]} !== {cyc >= 93, cyc == 93}) begin n_fail++; $display("FAIL reen_ch0 cyc=%0d got=%b%b exp=%b%b", cyc, reloj[0], pulso[0], cyc >= 93, cyc == 93); end
    end
  endtask

  task automatic test_write_collision;
    while (cyc < 104) begin
      step();
      n_chk++; if ({reloj[0], pulso[0]} !== 2'b10) begin n_fail++; $display("FAIL pre_col_ch0 cyc=%0d got=%b%b exp=10", cyc, reloj[0], pulso[0]); end
    end
    write(1'b0, 4'd3);
    while (1) begin
      n_chk++; if ({reloj[0], pulso[0]} !== {cyc < 117, cyc == 117}) begin n_fail++; $display("FAIL col_ch0 cyc=%0d got=%b%b exp=%b%b", cyc, reloj[0], pulso[0], cyc < 117, cyc == 117); end
      if (cyc >= 117) break;
      step();
    end
  endtask

  task automatic test_reset_midrun;
    write(1'b0, 4'd7);
    while (cyc < 122) step();
    rst = 1'b1;
    step();
    n_chk++; if (tick !== 1'b0)   begin n_fail++; $display("FAIL mid_reset_tick got=%b exp=0", tick); end
    n_chk++; if (pulso !== 2'b00) begin n_fail++; $display("FAIL mid_reset_pulso got=%b exp=00", pulso); end
    n_chk++; if (reloj !== 2'b00) begin n_fail++; $display("FAIL mid_reset_reloj got=%b exp=00", reloj); end
    rst = 1'b0;
    cyc = 0;
    test_startup("after_reset");
  endtask

  initial begin
    test_reset();
    test_startup("startup");
    test_write_period();
    test_stall();
    test_disable();
    test_write_collision();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reloj_ms_multicanal.md
Name: reloj_ms_multicanal

Overview:
Parametrised, multi-channel successor to the single-period millisecond clock divider. A shared prescaler turns clock_FPGA into a 1 ms strobe. 2^ANCHO_CANAL independent channels each divide that strobe by a period (in ms) that can be reprogrammed at runtime. Each channel provides a one-cycle pulse and a 50 % square wave. Consumers are the 7-segment digit multiplexer, blink timers and debounce sampling.

Parameters:
CICLOS_POR_MS, 50000, clock_FPGA cycles per ms (>= 2); prescaler width is $clog2(CICLOS_POR_MS).
ANCHO_CANAL, 2, channel-select width; NUM_CANALES = 2^ANCHO_CANAL.
ANCHO_MS, 16, width of each period register in ms.
PERIODO_INICIAL, 1, period loaded into every channel at reset (must be < 2^ANCHO_MS).

Ports:
clock_FPGA  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
habilitar  in  NUM_CANALES  per-channel enable.
wr_en  in  1  period-write strobe, sampled each cycle.
wr_canal  in  ANCHO_CANAL  channel index for the write.
wr_dato  in  ANCHO_MS  new period in ms.
tick_ms  out  1  one-cycle strobe every CICLOS_POR_MS cycles.
pulso_N_ms  out  NUM_CANALES  per-channel one-cycle pulse at end of period.
reloj_N_ms  out  NUM_CANALES  per-channel square wave, toggles at end of period.

Behaviour:
- Reset (synchronous, active-high; overrides everything):
  - prescaler, all channel counters = 0
  - tick_ms = 0, pulso_N_ms = 0, reloj_N_ms = 0
  - every periodo[i] = PERIODO_INICIAL
- Prescaler:
  - free-running 0..CICLOS_POR_MS-1, unaffected by habilitar.
  - On the edge where it equals CICLOS_POR_MS-1: wraps to 0 and registers tick_ms=1 for exactly one cycle.
  - First tick_ms is high during cycle CICLOS_POR_MS after reset release (first cycle with reset low = cycle 1).
- Channel i, evaluated on each edge in this priority order:
  1. wr_en && wr_canal==i: periodo[i] <= wr_dato; contador[i] <= 0; pulso[i] <= 0; reloj[i] unchanged. A write wins over a coincident terminal count: no pulse, no toggle.
  2. habilitar[i]==0: contador[i] <= 0; pulso[i] <= 0; reloj[i] <= 0.
  3. periodo[i]==0: channel stalled. contador[i] held at 0, pulso[i]=0, reloj[i] holds its value.
  4. tick_ms==1 and contador[i]==periodo[i]-1: contador[i] <= 0; pulso[i] <= 1; reloj[i] <= ~reloj[i].
  5. tick_ms==1 otherwise: contador[i] <= contador[i]+1.
  6. Else: pulso[i] <= 0; contador[i] holds.
- Latency: pulso[i] and the reloj[i] toggle appear one cycle after the tick_ms that completes the period.
- Output periods: pulses every periodo[i]*CICLOS_POR_MS cycles; reloj period = 2*periodo[i] ms.
- Period 1 gives one pulse per tick_ms.
- A write takes effect on the next edge. The first pulse arrives on the periodo-th tick_ms after the write.
- Re-enable: counting starts from 0. First pulse on the periodo-th tick_ms after habilitar rises; reloj starts at 0 and rises on that first pulse.
- Writes to one channel never disturb other channels or the prescaler.
- Counter arithmetic is ANCHO_MS bits unsigned; periodo 2^ANCHO_MS-1 is valid (no overflow since contador < periodo).

Test Plan:
Params for all scenarios: CICLOS_POR_MS=4, ANCHO_CANAL=1, ANCHO_MS=4, PERIODO_INICIAL=3.
1. Reset 2 cycles, release, habilitar=2'b11 -> tick_ms high in cycles 4,8,12,...; pulso_N_ms=2'b11 in cycles 13,25,37; reloj_N_ms rises at 13, falls at 25 (24-cycle period).
2. After scenario 1, wr_en with wr_canal=1, wr_dato=1 -> pulso[1] one cycle after every tick_ms, reloj[1] toggles every 4 cycles; channel 0 timing unchanged.
3. Write wr_dato=0 to channel 0 while reloj[0]=1 -> no further pulso[0]; reloj[0] stays 1; write 3 again -> first pulse one cycle after the 3rd subsequent tick_ms.
4. Drop habilitar[0] mid-period with reloj[0]=1 -> next cycle reloj[0]=0, pulso[0]=0; raise again -> pulse one cycle after the 3rd following tick_ms.
5. wr_en to channel 0 on the same edge its terminal count would fire -> no pulso[0], no toggle; next pulse 3 ticks later.
6. Assert reset mid-operation with periods 1 and 7 -> all outputs 0 next cycle; after release both channels behave exactly as in scenario 1 (periodo = 3).
